// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS32 multi-cycle sequencer:
// opcodes, FSM states and datapath mux selects.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_REXEC,
        S_RWB,
        S_BRANCH,
        S_JUMP,
        S_JAL,
        S_ORIEXEC,
        S_ORIWB,
        S_LUIWB,
        S_ILLEGAL
    } state_e;

    localparam logic [1:0] SRCB_B   = 2'b00;
    localparam logic [1:0] SRCB_4   = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;
    localparam logic [1:0] SRCB_BR  = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OR    = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] MTR_ALUOUT = 2'b00;
    localparam logic [1:0] MTR_MDR    = 2'b01;
    localparam logic [1:0] MTR_PC     = 2'b10;
    localparam logic [1:0] MTR_LUI    = 2'b11;

    function automatic state_e dispatch(input logic [5:0] opc);
        state_e s;
        case (opc)
            OP_LW, OP_SW:   s = S_MEMADR;
            OP_RTYPE:       s = S_REXEC;
            OP_BEQ, OP_BNE: s = S_BRANCH;
            OP_J:           s = S_JUMP;
            OP_JAL:         s = S_JAL;
            OP_ORI:         s = S_ORIEXEC;
            OP_LUI:         s = S_LUIWB;
            default:        s = S_ILLEGAL;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS32 control FSM, one datapath phase per clock.
// Define MULTICYCLE_TRAP_EN to make unknown opcodes trap (illegal_op).
module multicycle_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       pc_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       sign_ext,
    output logic [1:0] pc_src,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
`ifdef MULTICYCLE_TRAP_EN
    output logic       illegal_op,
`endif
    output logic       instr_done
);

    state_e state_q;
    state_e state_d;

`ifdef MULTICYCLE_TRAP_EN
    logic illegal_q;
    logic illegal_d;

    assign illegal_d  = illegal_q | (state_d == S_ILLEGAL);
    assign illegal_op = rst_n & illegal_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
`ifdef MULTICYCLE_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
`ifdef MULTICYCLE_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:   if (mem_ready) state_d = S_DECODE;
            S_DECODE:  state_d = dispatch(op);
            S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:   if (mem_ready) state_d = S_FETCH;
            S_REXEC:   state_d = S_RWB;
            S_ORIEXEC: state_d = S_ORIWB;
`ifdef MULTICYCLE_TRAP_EN
            S_ILLEGAL: state_d = S_ILLEGAL;
`else
            S_ILLEGAL: state_d = S_FETCH;
`endif
            S_MEMWB, S_RWB, S_BRANCH, S_JUMP,
            S_JAL, S_ORIWB, S_LUIWB:
                state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    // Reset gates every output low, sign_ext included.
    always_comb begin
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        pc_write   = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        alu_op     = ALU_ADD;
        sign_ext   = 1'b0;
        pc_src     = PC_ALU;
        reg_dst    = DST_RT;
        mem_to_reg = MTR_ALUOUT;
        instr_done = 1'b0;
        if (rst_n) begin
            sign_ext = 1'b1;
            unique case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_4;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: alu_src_b = SRCB_BR;
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = MTR_MDR;
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    mem_write  = 1'b1;
                    i_or_d     = 1'b1;
                    instr_done = mem_ready;
                end
                S_REXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_FUNCT;
                end
                S_RWB: begin
                    reg_write  = 1'b1;
                    reg_dst    = DST_RD;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a  = 1'b1;
                    alu_op     = ALU_SUB;
                    pc_src     = PC_ALUOUT;
                    pc_write   = ((op == OP_BEQ) & zero) |
                                 ((op == OP_BNE) & ~zero);
                    instr_done = 1'b1;
                end
                S_JUMP: begin
                    pc_write   = 1'b1;
                    pc_src     = PC_JUMP;
                    instr_done = 1'b1;
                end
                S_JAL: begin
                    pc_write   = 1'b1;
                    pc_src     = PC_JUMP;
                    reg_write  = 1'b1;
                    reg_dst    = DST_RA;
                    mem_to_reg = MTR_PC;
                    instr_done = 1'b1;
                end
                S_ORIEXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALU_OR;
                    sign_ext  = 1'b0;
                end
                S_ORIWB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_LUIWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = MTR_LUI;
                    instr_done = 1'b1;
                end
`ifdef MULTICYCLE_TRAP_EN
                S_ILLEGAL: instr_done = 1'b0;
`else
                S_ILLEGAL: instr_done = 1'b1;
`endif
                default: instr_done = 1'b0;
            endcase
        end
    end

endmodule
